monster_unit: RTL and testbench

Parametrised successor to the single-hit wandering monster. Each instance owns one monster: position, heading, multi-hit health, hurt cooldown, death animation and a chase mode that steers toward the player within range. The stage controller instantiates N copies, each with its own random tap. Outputs feed the sprite renderer and the stage-clear logic.

---
 rtl/monster_unit.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_monster_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monster_unit.sv
`default_nettype none
// ============================================================================
// Module   : monster_unit
// Purpose  : One wandering arena monster: position/heading, multi-hit health,
//            hurt cooldown, death blink animation and a chase mode that steers
//            toward the player when within Manhattan range.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            stage               - game stage (0, 0xE, 0xF = inactive)
//            wall_collision      - blocked flags [0]L [1]R [2]D [3]U
//            enable_weapon_collision, weapon_collision - hit qualifiers
//            player_h, player_v  - player position
//            rnd                 - per-instance random value
//            state               - sprite frame (0/1 walk, 2 hurt, 0xF hidden)
//            pos_h, pos_v        - monster position
//            direction           - 0 right, 1 left, 2 down, 3 up
//            hp, is_dead, hit_flash - health and status
// Revision : 1.0 - initial release
// ============================================================================
module monster_unit #(
   parameter int unsigned H_MIN        = 20,
   parameter int unsigned H_MAX        = 300,
   parameter int unsigned V_MIN        = 20,
   parameter int unsigned V_MAX        = 220,
   parameter int unsigned START_H      = 20,
   parameter int unsigned START_V      = 120,
   parameter int unsigned STEP         = 1,
   parameter int unsigned MOVE_DIV     = 1,
   parameter int unsigned TURN_PERIOD  = 50,
   parameter int unsigned HP           = 3,
   parameter int unsigned HIT_COOLDOWN = 16,
   parameter int unsigned DEATH_TICKS  = 50,
   parameter int unsigned ANIM_PERIOD  = 8,
   parameter int unsigned CHASE_RANGE  = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  stage,
   input  logic [3:0]  wall_collision,
   input  logic        enable_weapon_collision,
   input  logic        weapon_collision,
   input  logic [9:0]  player_h,
   input  logic [9:0]  player_v,
   input  logic [12:0] rnd,
   output logic [3:0]  state,
   output logic [9:0]  pos_h,
   output logic [9:0]  pos_v,
   output logic [1:0]  direction,
   output logic [3:0]  hp,
   output logic        is_dead,
   output logic        hit_flash
);

   localparam logic [10:0] c_H_MIN      = 11'(H_MIN);
   localparam logic [10:0] c_H_MAX      = 11'(H_MAX);
   localparam logic [10:0] c_V_MIN      = 11'(V_MIN);
   localparam logic [10:0] c_V_MAX      = 11'(V_MAX);
   localparam logic [10:0] c_STEP       = 11'(STEP);
   localparam logic [9:0]  c_STEP10     = 10'(STEP);
   localparam logic [10:0] c_RANGE      = 11'(CHASE_RANGE);
   localparam logic [9:0]  c_START_H    = 10'(START_H);
   localparam logic [9:0]  c_START_V    = 10'(START_V);
   localparam logic [3:0]  c_HP         = 4'(HP);
   localparam logic [15:0] c_ANIM_LAST  = 16'(ANIM_PERIOD - 1);
   localparam logic [15:0] c_DIV_LAST   = 16'(MOVE_DIV - 1);
   localparam logic [15:0] c_TURN_LAST  = 16'(TURN_PERIOD - 1);
   localparam logic [15:0] c_COOL       = 16'(HIT_COOLDOWN);
   localparam logic [15:0] c_DEATH      = 16'(DEATH_TICKS);

   localparam logic [1:0]  c_RIGHT = 2'd0;
   localparam logic [1:0]  c_LEFT  = 2'd1;
   localparam logic [1:0]  c_DOWN  = 2'd2;
   localparam logic [1:0]  c_UP    = 2'd3;

   typedef enum logic [1:0] {
      S_WALK  = 2'd0,
      S_HURT  = 2'd1,
      S_DYING = 2'd2,
      S_DEAD  = 2'd3
   } fsm_t;

   fsm_t        r_fsm,   w_fsm_n;
   logic [9:0]  r_pos_h, w_pos_h_n;
   logic [9:0]  r_pos_v, w_pos_v_n;
   logic [1:0]  r_dir,   w_dir_n;
   logic [3:0]  r_hp,    w_hp_n;
   logic        r_dead,  w_dead_n;
   logic        r_flash, w_flash_n;
   logic [3:0]  r_state, w_state_n;
   logic [15:0] r_anim,  w_anim_n;
   logic [15:0] r_div,   w_div_n;
   logic [15:0] r_turn,  w_turn_n;
   logic [15:0] r_cd,    w_cd_n;
   logic [15:0] r_dc,    w_dc_n;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic        w_active;
   logic        w_hit;
   logic [10:0] w_ph, w_pv, w_pl_h, w_pl_v;
   logic [10:0] w_dh, w_dv, w_dist;
   logic        w_near;
   logic [3:0]  w_blk;
   logic        w_cur_blk;
   logic [10:0] w_sum_h, w_sum_v;
   logic [9:0]  w_right, w_left, w_down, w_up;
   logic [1:0]  w_hdir, w_vdir, w_prim, w_alt;
   logic [1:0]  w_chase_dir, w_turn_dir, w_new_dir;
   logic        w_turn_wrap;
   logic        w_unused;

   // Only the two low random bits pick headings.
   assign w_unused = ^rnd[12:2];

   assign w_active = (stage != 4'h0) && (stage != 4'hE) && (stage != 4'hF);
   assign w_hit    = enable_weapon_collision & weapon_collision & (r_fsm == S_WALK);

   assign w_ph   = {1'b0, r_pos_h};
   assign w_pv   = {1'b0, r_pos_v};
   assign w_pl_h = {1'b0, player_h};
   assign w_pl_v = {1'b0, player_v};
   assign w_dh   = (w_pl_h >= w_ph) ? (w_pl_h - w_ph) : (w_ph - w_pl_h);
   assign w_dv   = (w_pl_v >= w_pv) ? (w_pl_v - w_pv) : (w_pv - w_pl_v);
   assign w_dist = w_dh + w_dv;
   assign w_near = (w_dist <= c_RANGE);

   // A heading is blocked by its wall flag or by already sitting on the bound;
   // short of the bound the step is clamped instead of refused.
   assign w_blk[0] = wall_collision[1] | (w_ph >= c_H_MAX);
   assign w_blk[1] = wall_collision[0] | (w_ph <= c_H_MIN);
   assign w_blk[2] = wall_collision[2] | (w_pv >= c_V_MAX);
   assign w_blk[3] = wall_collision[3] | (w_pv <= c_V_MIN);
   assign w_cur_blk = w_blk[r_dir];

   assign w_sum_h = w_ph + c_STEP;
   assign w_sum_v = w_pv + c_STEP;
   assign w_right = (w_sum_h > c_H_MAX) ? c_H_MAX[9:0] : w_sum_h[9:0];
   assign w_down  = (w_sum_v > c_V_MAX) ? c_V_MAX[9:0] : w_sum_v[9:0];
   assign w_left  = (w_ph < (c_H_MIN + c_STEP)) ? c_H_MIN[9:0] : (r_pos_h - c_STEP10);
   assign w_up    = (w_pv < (c_V_MIN + c_STEP)) ? c_V_MIN[9:0] : (r_pos_v - c_STEP10);

   // Chase: dominant axis first (tie favours horizontal), fall back to the
   // other axis when the dominant heading is blocked.
   assign w_hdir = (w_pl_h > w_ph) ? c_RIGHT : c_LEFT;
   assign w_vdir = (w_pl_v > w_pv) ? c_DOWN  : c_UP;
   assign w_prim = (w_dh >= w_dv) ? w_hdir : w_vdir;
   assign w_alt  = (w_dh >= w_dv) ? w_vdir : w_hdir;

   always_comb begin
      w_chase_dir = w_prim;
      if (w_dist == 11'd0) begin
         w_chase_dir = r_dir;
      end else if (w_blk[w_prim]) begin
         w_chase_dir = w_alt;
      end
   end

   // A blocked heading always turns to a different one.
   assign w_turn_dir  = (rnd[1:0] == r_dir) ? (rnd[1:0] + 2'd1) : rnd[1:0];
   assign w_turn_wrap = (r_turn >= c_TURN_LAST);

   always_comb begin
      w_new_dir = r_dir;
      if (w_near) begin
         w_new_dir = w_chase_dir;
      end else if (w_cur_blk) begin
         w_new_dir = w_turn_dir;
      end else if (w_turn_wrap) begin
         w_new_dir = rnd[1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_fsm_n   = r_fsm;
      w_pos_h_n = r_pos_h;
      w_pos_v_n = r_pos_v;
      w_dir_n   = r_dir;
      w_hp_n    = r_hp;
      w_dead_n  = r_dead;
      w_flash_n = r_flash;
      w_state_n = r_state;
      w_anim_n  = r_anim;
      w_div_n   = r_div;
      w_turn_n  = r_turn;
      w_cd_n    = r_cd;
      w_dc_n    = r_dc;

      case (r_fsm)
         S_WALK: begin
            if (w_hit) begin
               w_anim_n = 16'd0;
               if (r_hp > 4'd1) begin
                  w_fsm_n   = S_HURT;
                  w_hp_n    = r_hp - 4'd1;
                  w_flash_n = 1'b1;
                  w_state_n = 4'h2;
                  w_cd_n    = c_COOL;
               end else begin
                  w_fsm_n   = S_DYING;
                  w_hp_n    = 4'd0;
                  w_dead_n  = 1'b1;
                  w_state_n = 4'h1;
                  w_dc_n    = c_DEATH;
               end
            end else begin
               // Walk frame: the hidden frame after reset becomes frame 0
               // immediately, then frames alternate every ANIM_PERIOD cycles.
               if (r_state == 4'hF) begin
                  w_state_n = 4'h0;
                  w_anim_n  = 16'd0;
               end else if (r_anim >= c_ANIM_LAST) begin
                  w_anim_n  = 16'd0;
                  w_state_n = {3'b000, ~r_state[0]};
               end else begin
                  w_anim_n  = r_anim + 16'd1;
               end

               if (r_div >= c_DIV_LAST) begin
                  w_div_n = 16'd0;
                  if (!w_cur_blk) begin
                     case (r_dir)
                        c_RIGHT: w_pos_h_n = w_right;
                        c_LEFT:  w_pos_h_n = w_left;
                        c_DOWN:  w_pos_v_n = w_down;
                        default: w_pos_v_n = w_up;
                     endcase
                  end
                  w_dir_n = w_new_dir;
                  // The turn counter also restarts once it reaches the period,
                  // even when chase overrode the forced turn.
                  if ((w_new_dir != r_dir) || w_turn_wrap) begin
                     w_turn_n = 16'd0;
                  end else begin
                     w_turn_n = r_turn + 16'd1;
                  end
               end else begin
                  w_div_n = r_div + 16'd1;
               end
            end
         end

         S_HURT: begin
            // Loaded with HIT_COOLDOWN; the cycle that would count it to zero
            // is the last HURT cycle.
            if (r_cd <= 16'd1) begin
               w_fsm_n   = S_WALK;
               w_cd_n    = 16'd0;
               w_flash_n = 1'b0;
               w_state_n = 4'h0;
               w_anim_n  = 16'd0;
            end else begin
               w_cd_n = r_cd - 16'd1;
            end
         end

         S_DYING: begin
            if (r_dc <= 16'd1) begin
               w_fsm_n   = S_DEAD;
               w_dc_n    = 16'd0;
               w_state_n = 4'hF;
            end else begin
               w_dc_n = r_dc - 16'd1;
               if (r_anim >= c_ANIM_LAST) begin
                  w_anim_n  = 16'd0;
                  w_state_n = (r_state == 4'h1) ? 4'hF : 4'h1;
               end else begin
                  w_anim_n  = r_anim + 16'd1;
               end
            end
         end

         S_DEAD: begin
            w_state_n = 4'hF;
         end

         default: begin
            w_fsm_n = S_WALK;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register; an inactive stage behaves exactly like reset.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || !w_active) begin
         r_fsm   <= S_WALK;
         r_pos_h <= c_START_H;
         r_pos_v <= c_START_V;
         r_dir   <= c_RIGHT;
         r_hp    <= c_HP;
         r_dead  <= 1'b0;
         r_flash <= 1'b0;
         r_state <= 4'hF;
         r_anim  <= 16'd0;
         r_div   <= 16'd0;
         r_turn  <= 16'd0;
         r_cd    <= 16'd0;
         r_dc    <= 16'd0;
      end else begin
         r_fsm   <= w_fsm_n;
         r_pos_h <= w_pos_h_n;
         r_pos_v <= w_pos_v_n;
         r_dir   <= w_dir_n;
         r_hp    <= w_hp_n;
         r_dead  <= w_dead_n;
         r_flash <= w_flash_n;
         r_state <= w_state_n;
         r_anim  <= w_anim_n;
         r_div   <= w_div_n;
         r_turn  <= w_turn_n;
         r_cd    <= w_cd_n;
         r_dc    <= w_dc_n;
      end
   end

   assign state     = r_state;
   assign pos_h     = r_pos_h;
   assign pos_v     = r_pos_v;
   assign direction = r_dir;
   assign hp        = r_hp;
   assign is_dead   = r_dead;
   assign hit_flash = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_monster_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_monster_unit
// Purpose  : Self-checking bench for monster_unit. Two instances (default
//            pacing, and STEP=3 / MOVE_DIV=4) share one stimulus stream and
//            are compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_monster_unit;

   localparam int H_MIN = 20, H_MAX = 300, V_MIN = 20, V_MAX = 220;
   localparam int START_H = 20, START_V = 120;
   localparam int TURN_P = 50, HPV = 3, COOL = 16, DEATH = 50, ANIM = 8, RANGE = 64;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [3:0]  stage, walls;
   logic        en, wc;
   logic [9:0]  ph, pv;
   logic [12:0] rnd;

   logic [3:0]  a_state, b_state, a_hp, b_hp;
   logic [9:0]  a_h, a_v, b_h, b_v;
   logic [1:0]  a_dir, b_dir;
   logic        a_dead, b_dead, a_flash, b_flash;

   monster_unit u_a (
      .clk(clk), .rst(rst), .stage(stage), .wall_collision(walls),
      .enable_weapon_collision(en), .weapon_collision(wc),
      .player_h(ph), .player_v(pv), .rnd(rnd),
      .state(a_state), .pos_h(a_h), .pos_v(a_v), .direction(a_dir),
      .hp(a_hp), .is_dead(a_dead), .hit_flash(a_flash)
   );

   monster_unit #(.STEP(3), .MOVE_DIV(4)) u_b (
      .clk(clk), .rst(rst), .stage(stage), .wall_collision(walls),
      .enable_weapon_collision(en), .weapon_collision(wc),
      .player_h(ph), .player_v(pv), .rnd(rnd),
      .state(b_state), .pos_h(b_h), .pos_v(b_v), .direction(b_dir),
      .hp(b_hp), .is_dead(b_dead), .hit_flash(b_flash)
   );

   // mode: 0 walking, 1 hurt, 2 dying, 3 dead
   typedef struct packed {
      int h; int v; int dir; int hp; int dead; int flash; int st;
      int mode; int walk_k; int hurt_k; int die_k; int moves; int turn;
   } mdl_t;

   mdl_t ma, mb;
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m = '0;
      m.h = START_H; m.v = START_V; m.hp = HPV; m.st = 15;
      return m;
   endfunction

   function automatic bit is_blocked(int h, int v, int d);
      case (d)
         0:       return walls[1] || (h >= H_MAX);
         1:       return walls[0] || (h <= H_MIN);
         2:       return walls[2] || (v >= V_MAX);
         default: return walls[3] || (v <= V_MIN);
      endcase
   endfunction

   // One clock of behaviour, from the current input values.
   function automatic mdl_t mdl_step(mdl_t m_in, int step, int mdiv);
      mdl_t m;
      int   iph, ipv, dh, dv, nd, hd, vd, pri, alt, r, h0, v0;
      bit   blk, wrap;
      m = m_in;
      if (rst || stage == 4'h0 || stage == 4'hE || stage == 4'hF) return mdl_reset();
      iph = int'(ph); ipv = int'(pv); r = int'(rnd[1:0]);
      case (m.mode)
         0: begin
            if (en && wc) begin
               if (m.hp > 1) begin
                  m.hp -= 1; m.mode = 1; m.flash = 1; m.st = 2; m.hurt_k = 0;
               end else begin
                  m.hp = 0; m.dead = 1; m.mode = 2; m.st = 1; m.die_k = 0;
               end
            end else begin
               m.walk_k += 1;
               m.st = ((m.walk_k - 1) / ANIM) % 2;
               if ((m.moves % mdiv) == mdiv - 1) begin
                  h0 = m.h; v0 = m.v;
                  blk  = is_blocked(h0, v0, m.dir);
                  wrap = (m.turn == TURN_P - 1);
                  dh = (iph > h0) ? iph - h0 : h0 - iph;
                  dv = (ipv > v0) ? ipv - v0 : v0 - ipv;
                  if (dh + dv <= RANGE) begin
                     if (dh == 0 && dv == 0) nd = m.dir;
                     else begin
                        hd  = (iph > h0) ? 0 : 1;
                        vd  = (ipv > v0) ? 2 : 3;
                        pri = (dh >= dv) ? hd : vd;
                        alt = (dh >= dv) ? vd : hd;
                        nd  = is_blocked(h0, v0, pri) ? alt : pri;
                     end
                  end else if (blk) nd = (r == m.dir) ? (r + 1) % 4 : r;
                  else if (wrap)    nd = r;
                  else              nd = m.dir;
                  if (!blk) begin
                     case (m.dir)
                        0:       m.h = (h0 + step > H_MAX) ? H_MAX : h0 + step;
                        1:       m.h = (h0 - step < H_MIN) ? H_MIN : h0 - step;
                        2:       m.v = (v0 + step > V_MAX) ? V_MAX : v0 + step;
                        default: m.v = (v0 - step < V_MIN) ? V_MIN : v0 - step;
                     endcase
                  end
                  m.turn = (nd != m.dir || wrap) ? 0 : m.turn + 1;
                  m.dir  = nd;
               end
               m.moves += 1;
            end
         end
         1: begin
            m.hurt_k += 1;
            if (m.hurt_k >= COOL) begin
               m.mode = 0; m.flash = 0; m.st = 0; m.walk_k = 1;
            end
         end
         2: begin
            m.die_k += 1;
            if (m.die_k >= DEATH) begin
               m.mode = 3; m.st = 15;
            end else begin
               m.st = ((m.die_k / ANIM) % 2 == 1) ? 15 : 1;
            end
         end
         default: m.st = 15;
      endcase
      return m;
   endfunction

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("a.pos_h",     16'(a_h),     16'(ma.h));
      chk("a.pos_v",     16'(a_v),     16'(ma.v));
      chk("a.direction", 16'(a_dir),   16'(ma.dir));
      chk("a.state",     16'(a_state), 16'(ma.st));
      chk("a.hp",        16'(a_hp),    16'(ma.hp));
      chk("a.is_dead",   16'(a_dead),  16'(ma.dead));
      chk("a.hit_flash", 16'(a_flash), 16'(ma.flash));
      chk("b.pos_h",     16'(b_h),     16'(mb.h));
      chk("b.pos_v",     16'(b_v),     16'(mb.v));
      chk("b.direction", 16'(b_dir),   16'(mb.dir));
      chk("b.state",     16'(b_state), 16'(mb.st));
      chk("b.hp",        16'(b_hp),    16'(mb.hp));
      chk("b.is_dead",   16'(b_dead),  16'(mb.dead));
      chk("b.hit_flash", 16'(b_flash), 16'(mb.flash));
   endtask

   // Inputs are stable across the edge; outputs are sampled 1 ns later.
   task automatic cyc();
      @(posedge clk);
      ma = mdl_step(ma, 1, 1);
      mb = mdl_step(mb, 3, 4);
      #1;
      check_all();
   endtask

   function automatic logic [9:0] near(int c, int span);
      int x;
      x = c + $urandom_range(0, 2 * span) - span;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      return 10'(x);
   endfunction

   initial begin
      rst = 1'b1; stage = 4'h0; walls = 4'h0; en = 1'b0; wc = 1'b0;
      ph = 10'd500; pv = 10'd400; rnd = 13'd0;
      ma = mdl_reset(); mb = mdl_reset();

      // Reset state
      repeat (3) cyc();

      // Free walk, player far away
      rst = 1'b0; stage = 4'h1;
      for (int i = 0; i < 40; i++) begin rnd = 13'($urandom); cyc(); end

      // Random wall hits and arena bounds
      for (int i = 0; i < 400; i++) begin
         rnd   = 13'($urandom);
         walls = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         cyc();
      end
      walls = 4'h0;

      // Active-to-active stage change keeps state
      stage = 4'h2;
      for (int i = 0; i < 20; i++) begin rnd = 13'($urandom); cyc(); end

      // Chase: spawn at (20,120), player at (50,125)
      stage = 4'h0; cyc();
      stage = 4'h3; ph = 10'd50; pv = 10'd125;
      for (int i = 0; i < 150; i++) begin rnd = 13'($urandom); cyc(); end

      // Hits: HURT window, hit on HURT exit ignored, next cycle counts, kill
      stage = 4'h0; cyc();
      stage = 4'h1; ph = 10'd500; pv = 10'd400;
      for (int c = 1; c <= 140; c++) begin
         rnd = 13'($urandom);
         en  = (c == 7) || (c == 10) || (c == 12) || (c == 26) || (c == 27) ||
               (c == 45) || (c == 46) || (c == 110);
         wc  = en && (c != 7);
         if (c == 5) wc = 1'b1;
         cyc();
      end
      en = 1'b0; wc = 1'b0;

      // Inactive stage clears the dead monster
      stage = 4'h0; cyc(); cyc();
      stage = 4'h1;

      // Randomised soak
      for (int i = 0; i < 3000; i++) begin
         rnd   = 13'($urandom);
         walls = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         en    = ($urandom_range(0, 39) == 0);
         wc    = 1'($urandom);
         if (i % 64 == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               ph = near(ma.h, 40); pv = near(ma.v, 40);
            end else begin
               ph = 10'($urandom); pv = 10'($urandom);
            end
         end
         if (i % 500 == 250) stage = 4'($urandom);
         if (i % 500 == 260) stage = 4'h1;
         rst = (i == 1700);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
